// File: rtl/modport_shifter_pkg.sv
// Shared types, default sizing and golden shift function for the barrel shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package modport_shifter_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int SHIFT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Golden logical shift at the default width: zero fill on both sides, no rotation.
  function automatic logic [WIDTH_DEF-1:0] shift_ref(
    input logic [WIDTH_DEF-1:0]   data,
    input logic [SHIFT_W_DEF-1:0] shift,
    input dir_e                   dir
  );
    if (dir == DIR_RIGHT) begin
      return data >> shift;
    end
    return data << shift;
  endfunction

endpackage

// File: rtl/modport_shift_core.sv
// Combinational log-stage logical shifter: stage k moves the word by 2^k when shift[k] is set.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output tracks inputs continuously.
module modport_shift_core
  import modport_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH)-1:0] shift,
  input  dir_e                     dir,
  output logic [WIDTH-1:0]         shifted
);

  localparam int SHIFT_W = $clog2(WIDTH);

  // stage[0] is the raw operand; stage[SHIFT_W] is the fully shifted word.
  logic [SHIFT_W:0][WIDTH-1:0] stage;

  assign stage[0] = data;

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    localparam int STEP = 1 << k;
    logic [WIDTH-1:0] moved;
    // Both directions shift in zeros, so vacated bits never carry stale data.
    assign moved        = (dir == DIR_RIGHT) ? (stage[k] >> STEP) : (stage[k] << STEP);
    assign stage[k+1]   = shift[k] ? moved : stage[k];
  end

  assign shifted = stage[SHIFT_W];

endmodule

// File: rtl/modport_shifter.sv
// Registered logical barrel shifter; zero-fills vacated bits in either direction.
// Latency: 1 cycle from sampled operands to result; throughput one operation per cycle.
// Backpressure: none; every edge accepts new operands, synchronous reset clears result.
module modport_shifter
  import modport_shifter_pkg::*;
#(
  parameter  int WIDTH   = WIDTH_DEF,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               dir,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;

  modport_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data    (data),
    .shift   (shift),
    .dir     (dir_e'(dir)),
    .shifted (shifted)
  );

  // Reset wins over the shifted operand so an in-flight result is dropped.
  always_comb begin
    result_d = shifted;
    if (rst) begin
      result_d = '0;
    end
  end

  // Output register: the only state in the block, which keeps inputs off a comb path to result.
  always_ff @(posedge clk) begin
    result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_modport_shifter.sv
// Self-checking bench for the registered barrel shifter at WIDTH=4.
// Latency: expects result one edge after operands are applied.
// Backpressure: none; stimulus is driven every cycle.
module tb_modport_shifter;
  import modport_shifter_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] data;
  logic [1:0] shift;
  logic       dir;
  logic [3:0] result;

  int vectors;
  int miscompares;

  logic [3:0] exp_q;
  bit         have_exp;
  bit         cov_hit [8];

  modport_shifter #(
    .WIDTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .shift  (shift),
    .dir    (dir),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: arithmetic view of a logical shift on a 4-bit word.
  function automatic logic [3:0] model(input int d, input int s, input bit right);
    int p;
    p = 1;
    for (int i = 0; i < s; i++) p = p * 2;
    if (right) return 4'(d / p);
    return 4'((d * p) % 16);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply one operation; confirm result holds until the edge, then matches the model after it.
  task automatic step(input logic r, input logic [3:0] d, input logic [1:0] s,
                      input logic dr, input string tag, input int lit);
    rst   = r;
    data  = d;
    shift = s;
    dir   = dr;
    #1;
    if (have_exp) check({tag, "_hold"}, result, exp_q);
    @(posedge clk);
    #1;
    exp_q    = r ? 4'h0 : model(d, s, dr);
    have_exp = 1'b1;
    if (!r) cov_hit[{dr, s}] = 1'b1;
    check(tag, result, exp_q);
    if (lit >= 0) check({tag, "_lit"}, result, lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         order [128];
    int         tmp;
    int         j;
    logic [3:0] lv [4];
    logic [3:0] rv [4];

    vectors     = 0;
    miscompares = 0;
    have_exp    = 1'b0;
    rst   = 1'b1;
    data  = 4'h0;
    shift = 2'd0;
    dir   = 1'b0;
    lv[0] = 4'b1011; lv[1] = 4'b0110; lv[2] = 4'b1100; lv[3] = 4'b1000;
    rv[0] = 4'b1011; rv[1] = 4'b0101; rv[2] = 4'b0010; rv[3] = 4'b0001;

    // Golden package function against the independent model.
    for (int k = 0; k < 128; k++) begin
      check("shift_ref", shift_ref(4'(k & 15), 2'((k >> 4) & 3), dir_e'(k >> 6)),
            model(k & 15, (k >> 4) & 3, bit'(k >> 6)));
    end

    // Reset holds result at zero while inputs are busy.
    step(1'b1, 4'hF, 2'd2, 1'b0, "reset0", 0);
    step(1'b1, 4'hF, 2'd2, 1'b0, "reset1", 0);
    step(1'b0, 4'hA, 2'd0, 1'b0, "release", 4'hA);

    for (int s = 0; s < 4; s++) step(1'b0, 4'b1011, 2'(s), 1'b0, "left_sweep", lv[s]);
    for (int s = 0; s < 4; s++) step(1'b0, 4'b1011, 2'(s), 1'b1, "right_sweep", rv[s]);

    step(1'b0, 4'h9, 2'd1, 1'b0, "mixed0", 4'h2);
    step(1'b0, 4'h9, 2'd1, 1'b1, "mixed1", 4'h4);
    step(1'b0, 4'h8, 2'd3, 1'b1, "mixed2", 4'h1);
    step(1'b0, 4'h1, 2'd3, 1'b0, "mixed3", 4'h8);

    // Single-cycle reset pulse mid-stream, then normal operation resumes.
    step(1'b0, 4'h6, 2'd1, 1'b0, "pre_rst", 4'hC);
    step(1'b1, 4'hF, 2'd1, 1'b1, "mid_rst", 0);
    step(1'b0, 4'hF, 2'd1, 1'b1, "post_rst", 4'h7);

    // All 128 operand combinations in shuffled order.
    for (int k = 0; k < 128; k++) order[k] = k;
    for (int k = 127; k > 0; k--) begin
      j        = int'($urandom_range(k, 0));
      tmp      = order[k];
      order[k] = order[j];
      order[j] = tmp;
    end
    for (int k = 0; k < 128; k++) begin
      step(1'b0, 4'(order[k] & 15), 2'((order[k] >> 4) & 3), 1'(order[k] >> 6), "exhaustive", -1);
    end

    // Free-running random traffic with occasional resets.
    for (int k = 0; k < 150; k++) begin
      step(1'($urandom_range(15, 0) == 0), 4'($urandom), 2'($urandom), 1'($urandom), "random", -1);
    end

    for (int b = 0; b < 8; b++) check("cov_bin", 32'(cov_hit[b]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modport_shifter.md
Name: modport_shifter

Overview:
- Registered logical barrel shifter. It shifts a WIDTH-bit data word left or right by 0..WIDTH-1 positions and zero-fills vacated bits.
- The result is captured in an output register, so it appears one clock after the operands are sampled.
- Sits behind the barrel_if interface. The driver applies data/shift/dir on a clock edge; the monitor checks result on the following edge.

Parameters:
- WIDTH, default 4: data/result width in bits. Must be a power of two, ≥2.
- SHIFT_W, default $clog2(WIDTH) = 2: width of the shift-amount port. Derived; not to be overridden.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- data, input, WIDTH: operand to shift.
- shift, input, SHIFT_W: shift amount, unsigned, 0..WIDTH-1.
- dir, input, 1: direction. 0 = left (toward MSB), 1 = right (toward LSB).
- result, output, WIDTH: registered shifted value.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Every rising clk edge:
  - If rst=1, result <= 0.
  - Otherwise, result <= f(data, shift, dir), using the values sampled at that edge.
- Latency is exactly 1 cycle. There is no enable, valid or handshake; a new operation is accepted every cycle (throughput 1/cycle).
- Left shift (dir=0): result = data << shift. LSBs are zero-filled and bits shifted past the MSB are discarded. For WIDTH=4:
  - shift=1 gives {data[2:0],0}
  - shift=2 gives {data[1:0],00}
  - shift=3 gives {data[0],000}
- Right shift (dir=1): logical. result = data >> shift, MSBs zero-filled, no sign extension, no rotation. For WIDTH=4:
  - shift=1 gives {0,data[3:1]}
  - shift=2 gives {00,data[3:2]}
  - shift=3 gives {000,data[3]}
- shift=0 passes data through unchanged for both dir values.
- Reset:
  - result reads 0 from the first edge with rst=1 and holds 0 while rst stays high. Inputs are ignored during reset.
  - Asserting rst mid-stream discards any result in flight.
  - The first edge with rst=0 captures the inputs present at that edge, so result is valid one cycle after reset deasserts.
- After reset, result has no dependence on history; it is a pure function of the previous-edge inputs.
- Shift core is combinational: log2(WIDTH) mux stages, where stage k shifts by 2^k when shift[k]=1. No combinational path exists from the inputs to result.

Decomposition:
- Package modport_shifter_pkg holds:
  - localparam WIDTH_DEF=4
  - typedef enum logic {DIR_LEFT=1'b0, DIR_RIGHT=1'b1} dir_e
  - function shift_ref(data, shift, dir), a golden model shared with the bench scoreboard.
- One sub-module, modport_shift_core:
  - Parameterised by WIDTH.
  - Purely combinational log-stage shifter (data, shift, dir -> shifted).
- The top holds only the output register and reset.

Test Plan:
- Reset: rst=1 for 2 cycles with data=4'hF, shift=2, dir=0 -> result=4'h0 throughout. Release rst with data=4'hA, shift=0 -> result=4'hA one edge later.
- Left sweep: data=4'b1011, dir=0, shift=0,1,2,3 on consecutive cycles -> result=1011, 0110, 1100, 1000, each one cycle after its stimulus.
- Right sweep: data=4'b1011, dir=1, shift=0,1,2,3 -> result=1011, 0101, 0010, 0001 (zero fill, no sign extension).
- Back-to-back mixed: a different (data, shift, dir) every cycle, e.g. (4'h9,1,L) -> 4'h2, (4'h9,1,R) -> 4'h4, (4'h8,3,R) -> 4'h1, (4'h1,3,L) -> 4'h8. Each result appears on the next edge.
- Mid-stream reset: rst pulses high for one cycle while data=4'hF, shift=1, dir=1 -> result=0 on that edge; the next non-reset edge resumes normal results.
- Exhaustive random: all 128 combinations of data, shift and dir, plus random reordering, checked against shift_ref with 1-cycle delay -> zero mismatches. All 8 (dir, shift) coverage bins are hit.
